// File: rtl/sysid_probe_master.sv
// Purpose: boot-time self-check that reads sysid word 0 (ID) and word 1 (timestamp) and compares them to the expected image.
// Latency: start sampled at edge k gives done in cycle k+3 with no wait states; each waitrequest cycle adds one cycle.
// Backpressure: avm_read/avm_address held while avm_waitrequest is high; a read stalled TIMEOUT_CYCLES cycles aborts with code 11.
module sysid_probe_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1519145854,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  error_code,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value
);

  // A zero timeout means a stalled read waits forever.
  localparam logic        TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ID      = 2'b01;
  localparam logic [1:0] ERR_TS      = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_RD_TS,
    ST_REPORT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] stall_q, stall_d;
  logic [31:0] id_d, ts_d;
  logic        pass_d;
  logic [1:0]  err_d;
  logic        stall_expired;

  // The last permitted stall cycle of a read; the abort is taken on this edge.
  assign stall_expired = TMO_EN && avm_waitrequest && (stall_q == TMO_LAST);

  // Next-state, capture and result computation; everything holds unless a transition updates it.
  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    id_d    = id_value;
    ts_d    = timestamp_value;
    pass_d  = pass;
    err_d   = error_code;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RD_ID;
          stall_d = 16'd0;
          pass_d  = 1'b0;
          err_d   = ERR_NONE;
        end
      end
      ST_RD_ID: begin
        if (avm_waitrequest) begin
          if (stall_expired) begin
            state_d = ST_REPORT;
            err_d   = ERR_TIMEOUT;
            pass_d  = 1'b0;
          end else begin
            stall_d = stall_q + 16'd1;
          end
        end else begin
          id_d    = avm_readdata;
          stall_d = 16'd0;
          state_d = ST_RD_TS;
        end
      end
      ST_RD_TS: begin
        if (avm_waitrequest) begin
          if (stall_expired) begin
            state_d = ST_REPORT;
            err_d   = ERR_TIMEOUT;
            pass_d  = 1'b0;
          end else begin
            stall_d = stall_q + 16'd1;
          end
        end else begin
          ts_d    = avm_readdata;
          stall_d = 16'd0;
          state_d = ST_REPORT;
          // ID mismatch outranks timestamp mismatch; id_value already holds this probe's word 0.
          if (id_value != EXPECTED_ID) begin
            err_d = ERR_ID;
          end else if (avm_readdata != EXPECTED_TIMESTAMP) begin
            err_d = ERR_TS;
          end else begin
            err_d = ERR_NONE;
          end
          pass_d = (id_value == EXPECTED_ID) && (avm_readdata == EXPECTED_TIMESTAMP);
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, captured words and results; reset abandons any outstanding read at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      stall_q         <= 16'd0;
      id_value        <= 32'd0;
      timestamp_value <= 32'd0;
      pass            <= 1'b0;
      error_code      <= ERR_NONE;
    end else begin
      state_q         <= state_d;
      stall_q         <= stall_d;
      id_value        <= id_d;
      timestamp_value <= ts_d;
      pass            <= pass_d;
      error_code      <= err_d;
    end
  end

  // Bus strobes and status flags are decoded from the next state so they leave flops directly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      avm_read    <= (state_d == ST_RD_ID) || (state_d == ST_RD_TS);
      avm_address <= (state_d == ST_RD_TS);
      busy        <= (state_d != ST_IDLE);
      done        <= (state_d == ST_REPORT);
    end
  end

endmodule

// File: tb/tb_sysid_probe_master.sv
// Purpose: randomized scoreboard bench for the sysid probe master against a transaction-level model.
// Latency: expected done cycle derived from per-word wait counts and the timeout limit.
// Backpressure: a behavioural slave inserts per-word waitrequest stalls, including stuck-high stalls.
module tb_sysid_probe_master;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1519145854;
  localparam int          T      = 4;
  localparam int          STUCK  = 1000;

  typedef struct {
    int          cyc;
    logic        pass;
    logic [1:0]  err;
    logic [31:0] id;
    logic [31:0] ts;
    int          rdc;
    logic        a1;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address, avm_read, busy, done, pass;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_waitrequest = 1'b0;
  logic [1:0]  error_code;
  logic [31:0] id_value, timestamp_value;

  logic        nt_rst_n = 1'b0;
  logic        nt_start = 1'b0;
  logic        nt_address, nt_read, nt_busy, nt_done, nt_pass;
  logic [1:0]  nt_err;
  logic [31:0] nt_id, nt_ts;
  logic        nt_wait = 1'b1;
  logic [31:0] nt_rdata = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  exp_t sb[$];

  logic [31:0] model_id = 32'd0;
  logic [31:0] model_ts = 32'd0;
  logic [31:0] cfg_d[2];
  int          cfg_w[2];

  sysid_probe_master #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .pass(pass), .error_code(error_code),
    .id_value(id_value), .timestamp_value(timestamp_value)
  );

  sysid_probe_master #(.TIMEOUT_CYCLES(0)) dut_nt (
    .clock(clock), .reset_n(nt_rst_n), .start(nt_start),
    .avm_address(nt_address), .avm_read(nt_read),
    .avm_readdata(nt_rdata), .avm_waitrequest(nt_wait),
    .busy(nt_busy), .done(nt_done), .pass(nt_pass), .error_code(nt_err),
    .id_value(nt_id), .timestamp_value(nt_ts)
  );

  always #5 clock = ~clock;

  // Edge counter used to timestamp starts and dones.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level expectation: outcome decided by which word (if any) stalls past the limit.
  task automatic model_probe(input int w0, input int w1, input logic [31:0] d0,
                             input logic [31:0] d1, input int c, output exp_t e);
    e.a1 = 1'b0;
    if (w0 >= T) begin
      e.err = 2'b11; e.rdc = T; e.cyc = c + 1 + T;
    end else begin
      model_id = d0; e.a1 = 1'b1;
      if (w1 >= T) begin
        e.err = 2'b11; e.rdc = w0 + 1 + T; e.cyc = c + 2 + w0 + T;
      end else begin
        model_ts = d1; e.rdc = w0 + w1 + 2; e.cyc = c + 3 + w0 + w1;
        if (d0 != EXP_ID) e.err = 2'b01;
        else if (d1 != EXP_TS) e.err = 2'b10;
        else e.err = 2'b00;
      end
    end
    e.pass = (e.err == 2'b00);
    e.id   = model_id;
    e.ts   = model_ts;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 400 && done_cnt < target; i++) @(posedge clock);
    chk("done_seen", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic probe(input int w0, input int w1, input logic [31:0] d0, input logic [31:0] d1);
    exp_t e;
    int   target;
    cfg_w[0] = w0; cfg_w[1] = w1; cfg_d[0] = d0; cfg_d[1] = d1;
    @(negedge clock);
    model_probe(w0, w1, d0, d1, cyc, e);
    sb.push_back(e);
    target = done_cnt + 1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(target);
  endtask

  // Behavioural slave: stalls cfg_w[addr] cycles per word, returns junk while stalled.
  int   sc = 0;
  logic last_a = 1'b0;
  always @(posedge clock) begin
    #1;
    if (!avm_read) begin
      sc = 0; avm_waitrequest = 1'b0; avm_readdata = $urandom;
    end else begin
      if (avm_address != last_a) sc = 0;
      if (sc < cfg_w[avm_address]) begin
        avm_waitrequest = 1'b1; sc++; avm_readdata = $urandom;
      end else begin
        avm_waitrequest = 1'b0; avm_readdata = cfg_d[avm_address];
      end
    end
    last_a = avm_address;
  end

  // Monitor: bus protocol checks every cycle, scoreboard pop on each done.
  int   rd_cnt = 0;
  logic a1_seen = 1'b0;
  logic prev_rw = 1'b0;
  logic prev_a = 1'b0;
  always @(negedge clock) begin
    if (!reset_n) begin
      rd_cnt = 0; a1_seen = 1'b0; prev_rw = 1'b0;
    end else begin
      if (prev_rw && !done) begin
        chk("read_held", 32'(avm_read), 32'd1);
        chk("addr_held", 32'(avm_address), 32'(prev_a));
      end
      if (avm_read && rd_cnt == 0) chk("first_addr", 32'(avm_address), 32'd0);
      if (!avm_read && avm_address) chk("idle_addr", 32'(avm_address), 32'd0);
      if (avm_read) begin
        rd_cnt++;
        if (avm_address) a1_seen = 1'b1;
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no probe in flight (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("pass", 32'(pass), 32'(e.pass));
          chk("error_code", 32'(error_code), 32'(e.err));
          chk("id_value", id_value, e.id);
          chk("timestamp_value", timestamp_value, e.ts);
          chk("read_cycles", rd_cnt, e.rdc);
          chk("addr1_driven", 32'(a1_seen), 32'(e.a1));
          chk("busy_in_done", 32'(busy), 32'd1);
        end
        rd_cnt = 0; a1_seen = 1'b0;
        done_cnt++;
      end
      prev_rw = avm_read && avm_waitrequest;
      prev_a  = avm_address;
    end
  end

  int nt_rc = 0;
  int nt_dn = 0;

  initial begin
    cfg_d[0] = EXP_ID; cfg_d[1] = EXP_TS; cfg_w[0] = 0; cfg_w[1] = 0;
    fork
      begin : main_seq
        int c0, dc;
        exp_t e;
        @(posedge clock); #2;
        chk("rst_read", 32'(avm_read), 32'd0);
        chk("rst_addr", 32'(avm_address), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(error_code), 32'd0);
        chk("rst_id", id_value, 32'd0);
        chk("rst_ts", timestamp_value, 32'd0);
        @(negedge clock); reset_n = 1'b1;
        repeat (2) @(negedge clock);

        probe(0, 0, EXP_ID, EXP_TS);
        probe(0, 0, EXP_ID + 32'd1, EXP_TS);
        probe(0, 0, EXP_ID + 32'd1, 32'h1234_5678);
        probe(0, 0, EXP_ID, 32'h5A8C_0000);
        probe(3, 2, EXP_ID, EXP_TS);
        probe(0, 0, 32'hDEAD_BEEF, EXP_TS);
        probe(STUCK, 0, EXP_ID, EXP_TS);
        probe(1, STUCK, EXP_ID, EXP_TS);

        // start held high: exactly three back-to-back probes, one every 4 cycles.
        cfg_w[0] = 0; cfg_w[1] = 0; cfg_d[0] = EXP_ID; cfg_d[1] = EXP_TS;
        @(negedge clock);
        c0 = cyc; dc = done_cnt;
        for (int i = 0; i < 3; i++) begin
          model_probe(0, 0, EXP_ID, EXP_TS, c0 + 4 * i, e);
          sb.push_back(e);
        end
        start = 1'b1;
        repeat (9) @(negedge clock);
        start = 1'b0;
        wait_done(dc + 3);
        repeat (6) @(negedge clock);
        chk("b2b_probe_count", done_cnt, dc + 3);

        for (int i = 0; i < 40; i++) begin
          int r0, r1;
          logic [31:0] d0, d1;
          r0 = $urandom_range(0, 3); r1 = $urandom_range(0, 3);
          d0 = (r0 < 2) ? EXP_ID : (r0 == 2) ? EXP_ID + 32'd1 : 32'($urandom);
          d1 = (r1 < 2) ? EXP_TS : (r1 == 2) ? 32'h5A8C_0000 : 32'($urandom);
          probe($urandom_range(0, 5), $urandom_range(0, 5), d0, d1);
        end

        // Reset pulsed while the timestamp read is stalled.
        cfg_w[0] = 0; cfg_w[1] = 3; cfg_d[0] = EXP_ID; cfg_d[1] = EXP_TS;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        @(posedge clock); #2;
        chk("pre_rst_read_ts", 32'({avm_read, avm_address}), 32'd3);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_read", 32'(avm_read), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_pass", 32'(pass), 32'd0);
        chk("mid_rst_err", 32'(error_code), 32'd0);
        chk("mid_rst_id", id_value, 32'd0);
        dc = done_cnt;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        model_id = 32'd0; model_ts = 32'd0;
        repeat (8) @(negedge clock);
        chk("no_done_after_rst", done_cnt, dc);
        probe(0, 0, EXP_ID, 32'h5A8C_0000);
        probe(2, 1, EXP_ID, EXP_TS);
        chk("sb_drained", sb.size(), 0);
      end
      begin : no_timeout_seq
        repeat (2) @(negedge clock);
        nt_rst_n = 1'b1;
        @(negedge clock); nt_start = 1'b1;
        @(negedge clock); nt_start = 1'b0;
        repeat (70000) begin
          @(negedge clock);
          if (nt_read) nt_rc++;
          if (nt_done) nt_dn++;
        end
        chk("nt_read_cycles", nt_rc, 70000);
        chk("nt_done_count", nt_dn, 0);
        chk("nt_busy", 32'(nt_busy), 32'd1);
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
